// File: rtl/dlx_alu_pkg.sv
// Shared definitions for the DLX ALU and the multiply/divide sequencer.
package dlx_alu_pkg;

  // Shared ALU opcodes; the sequencer only ever issues add and sltu.
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00111;

  typedef enum logic [1:0] {
    MdMult  = 2'd0,
    MdMultu = 2'd1,
    MdDiv   = 2'd2,
    MdDivu  = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StIter,
    StFixLo,
    StFixHi,
    StDone
  } md_state_e;

  // Cycles from start acceptance to the done pulse.
  localparam int unsigned MD_LATENCY = 37;

endpackage

// File: rtl/md_alu_sequencer_if.sv
// Pipeline request/result bus plus the shared-ALU hookup of the sequencer.
interface md_alu_sequencer_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        div_by_zero;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_carryout;
  logic        alu_set;

  // Pipeline and shared ALU side.
  modport master (
    output start, md_op, a, b, alu_result, alu_carryout, alu_set,
    input  busy, done, result, result_hi, div_by_zero, alu_a, alu_b, alu_op
  );

  // Sequencer side.
  modport slave (
    input  start, md_op, a, b, alu_result, alu_carryout, alu_set,
    output busy, done, result, result_hi, div_by_zero, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/md_alu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that borrows the shared DLX ALU
// for every add/subtract, one ALU operation per cycle, fixed 37-cycle latency.
module md_alu_sequencer
  import dlx_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,  // only 32 is supported
  parameter int unsigned ITER = 32   // must equal XLEN
) (
  input logic               clk,
  input logic               reset,
  md_alu_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(ITER);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d;       // P_hi for multiply, R for divide
  logic [XLEN-1:0] lo_q, lo_d;       // P_lo for multiply, Q for divide
  logic [XLEN-1:0] a_orig_q, a_orig_d;
  logic            is_div_q, is_div_d;
  logic            sgn_q, sgn_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dbz_pend_q, dbz_pend_d;
  logic            dbz_q, dbz_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] result_hi_q, result_hi_d;

  logic [XLEN-1:0] alu_a, alu_b;
  logic [4:0]      alu_op;
  logic            take;
  logic [XLEN-1:0] opb_abs;
  logic [XLEN-1:0] hi_fin;

  // ALU operand drive; depends only on registered state so the external ALU
  // never forms a combinational loop back into the operands.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    unique case (state_q)
      StNegA: begin
        alu_b  = opa_q;
        alu_op = ALU_SLTU;
      end
      StNegB: begin
        alu_b  = opb_q;
        alu_op = ALU_SLTU;
      end
      StIter: begin
        if (is_div_q) begin
          alu_a  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          alu_b  = opb_q;
          alu_op = ALU_SLTU;
        end else begin
          alu_a  = hi_q;
          alu_b  = opa_q;
          alu_op = ALU_ADD;
        end
      end
      StFixLo: begin
        alu_b  = lo_q;
        alu_op = ALU_SLTU;
      end
      StFixHi: begin
        if (is_div_q) begin
          alu_b  = hi_q;
          alu_op = ALU_SLTU;
        end else begin
          // 64-bit negate of the high word: ~hi plus the borrow-free carry
          // that only propagates when the low word was zero.
          alu_a  = ~hi_q;
          alu_b  = {{(XLEN-1){1'b0}}, (lo_q == '0)};
          alu_op = ALU_ADD;
        end
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates from the ALU response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    a_orig_d    = a_orig_q;
    is_div_d    = is_div_q;
    sgn_d       = sgn_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    dbz_pend_d  = dbz_pend_q;
    dbz_d       = dbz_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    take        = 1'b0;
    opb_abs     = opb_q;
    hi_fin      = hi_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          opa_d      = bus.a;
          opb_d      = bus.b;
          a_orig_d   = bus.a;
          is_div_d   = bus.md_op[1];
          sgn_d      = ~bus.md_op[0];
          neg_res_d  = ~bus.md_op[0] & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
          neg_rem_d  = (bus.md_op == MdDiv) & bus.a[XLEN-1];
          dbz_pend_d = bus.md_op[1] & (bus.b == '0);
          dbz_d      = 1'b0;
          state_d    = StNegA;
        end
      end
      StNegA: begin
        if (sgn_q && opa_q[XLEN-1]) opa_d = bus.alu_result;
        state_d = StNegB;
      end
      StNegB: begin
        if (sgn_q && opb_q[XLEN-1]) opb_abs = bus.alu_result;
        opb_d   = opb_abs;
        hi_d    = '0;
        lo_d    = is_div_q ? opa_q : opb_abs;
        cnt_d   = '0;
        state_d = StIter;
      end
      StIter: begin
        if (is_div_q) begin
          // R[31] set means the 33-bit partial remainder already exceeds B.
          take = hi_q[XLEN-1] | ~bus.alu_set;
          hi_d = take ? bus.alu_result : alu_a;
          lo_d = {lo_q[XLEN-2:0], take};
        end else if (lo_q[0]) begin
          hi_d = {bus.alu_carryout, bus.alu_result[XLEN-1:1]};
          lo_d = {bus.alu_result[0], lo_q[XLEN-1:1]};
        end else begin
          hi_d = {1'b0, hi_q[XLEN-1:1]};
          lo_d = {hi_q[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) state_d = StFixLo;
      end
      StFixLo: begin
        if (neg_res_q) lo_d = bus.alu_result;
        state_d = StFixHi;
      end
      StFixHi: begin
        if (is_div_q ? neg_rem_q : neg_res_q) hi_fin = bus.alu_result;
        hi_d        = hi_fin;
        result_d    = dbz_pend_q ? '1 : lo_q;
        result_hi_d = dbz_pend_q ? a_orig_q : hi_fin;
        dbz_d       = dbz_pend_q;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      a_orig_q    <= '0;
      is_div_q    <= 1'b0;
      sgn_q       <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      dbz_q       <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      a_orig_q    <= a_orig_d;
      is_div_q    <= is_div_d;
      sgn_q       <= sgn_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dbz_pend_q  <= dbz_pend_d;
      dbz_q       <= dbz_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.result      = result_q;
  assign bus.result_hi   = result_hi_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_op      = alu_op;

endmodule

// File: tb/tb_md_alu_sequencer.sv
// Self-checking bench for md_alu_sequencer with a behavioural shared ALU.
module tb_md_alu_sequencer;
  import dlx_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  md_alu_sequencer_if bus ();

  md_alu_sequencer #(
    .XLEN(32),
    .ITER(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: add and sltu (Result = A-B, Set = A<B unsigned).
  logic [32:0] alu_sum;
  assign alu_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_result   = (bus.alu_op == ALU_SLTU) ? (bus.alu_a - bus.alu_b) : alu_sum[31:0];
  assign bus.alu_carryout = alu_sum[32];
  assign bus.alu_set      = (bus.alu_a < bus.alu_b);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint             sp;
    logic        [63:0] p;
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        sp = longint'(sa) * longint'(sb);
        p  = sp;
        return {1'b0, p};
      end
      2'd1: begin
        p = {32'h0, a} * {32'h0, b};
        return {1'b0, p};
      end
      2'd2: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, {62'h0, bus.busy, bus.done}, 64'h0);
    check({tag, "_alu"}, {bus.alu_a, bus.alu_b[26:0], bus.alu_op},
          {32'h0, 27'h0, ALU_ADD});
    check({tag, "_aluhi"}, {59'h0, bus.alu_b[31:27]}, 64'h0);
  endtask

  // Issues one operation from an idle negedge, checks busy/done every cycle
  // and the results at cycle 37, then returns at the idle negedge of cycle 38.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit glitch);
    logic [64:0] exp;
    bit          tim_ok;
    int          bad_cyc;
    exp       = ref_md(op, a, b);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.md_op = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    check({tag, "_dbz_clr"}, {63'h0, bus.div_by_zero}, 64'h0);
    tim_ok  = 1'b1;
    bad_cyc = 0;
    for (int c = 1; c <= int'(MD_LATENCY); c++) begin
      if (c > 1) @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== (c == int'(MD_LATENCY))) begin
        if (tim_ok) bad_cyc = c;
        tim_ok = 1'b0;
      end
      if (glitch && c == 5) begin
        bus.start = 1'b1;
        bus.md_op = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (c == 6) bus.start = 1'b0;
    end
    check({tag, "_timing"}, {63'h0, tim_ok}, 64'h1);
    if (!tim_ok) $display("  first bad cycle %0d", bad_cyc);
    check({tag, "_done_alu"}, {bus.alu_a, bus.alu_b[26:0], bus.alu_op},
          {32'h0, 27'h0, ALU_ADD});
    check({tag, "_res"}, {bus.result_hi, bus.result}, exp[63:0]);
    check({tag, "_dbz"}, {63'h0, bus.div_by_zero}, {63'h0, exp[64]});
    @(negedge clk);
    check({tag, "_hold"}, {bus.result_hi, bus.result}, exp[63:0]);
    check({tag, "_idle"}, {62'h0, bus.busy, bus.done}, 64'h0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 2'd0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_res", {bus.result_hi, bus.result}, 64'h0);
    check("rst_dbz", {63'h0, bus.div_by_zero}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_op("multu_max", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("mult_neg", MdMult, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_op("mult_min", MdMult, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op("mult_minx1", MdMult, 32'h8000_0000, 32'd1, 1'b0);
    do_op("div_neg", MdDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("div_ovf", MdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("divu_r31", MdDivu, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    do_op("divu_100_7", MdDivu, 32'd100, 32'd7, 1'b0);
    do_op("divu_zero", MdDivu, 32'h0000_1234, 32'h0, 1'b0);
    do_op("div_zero_neg", MdDiv, 32'hFFFF_FF00, 32'h0, 1'b0);
    do_op("after_dbz", MdMultu, 32'd3, 32'd5, 1'b0);
    do_op("start_ignored", MdMultu, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // Abort: start, ignored mid-op start at cycle 5, reset at cycle 10.
    bus.start = 1'b1;
    bus.md_op = MdMultu;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = (c == 5);
      if (c == 5) begin
        bus.md_op = MdDiv;
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      if (c == 9) check("abort_busy", {63'h0, bus.busy}, 64'h1);
      if (c == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check_idle("abort");
    check("abort_res", {bus.result_hi, bus.result}, 64'h0);
    check("abort_dbz", {63'h0, bus.div_by_zero}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    do_op("post_abort", MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Randomized operations against the reference.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'h0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      if (sel == 3) ra = 32'($urandom_range(0, 255));
      do_op($sformatf("rnd%0d", i), rop, ra, rb, (sel == 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/md_alu_sequencer.md
Name: md_alu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the DLX execute stage.
- Implements MULT, MULTU, DIV and DIVU with an iterative algorithm. It drives the shared 32-bit ALU through its A/B/Op ports, one ALU operation per cycle, instead of instantiating its own adder.
- The pipeline holds the execute stage while busy is high and captures result and result_hi on done.

Parameters:
- XLEN, 32, operand width; only 32 is supported.
- ITER, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- md_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  in  32  multiplicand or dividend
- b  in  32  multiplier or divisor
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; results valid from this cycle on
- result  out  32  product low word or quotient
- result_hi  out  32  product high word or remainder
- div_by_zero  out  1  sticky until the next accepted start
- alu_a  out  32  shared ALU operand A
- alu_b  out  32  shared ALU operand B
- alu_op  out  5  shared ALU opcode
- alu_result  in  32  ALU Result
- alu_carryout  in  1  ALU Carryout (carry of A+B)
- alu_set  in  1  ALU Set (A<B unsigned when op=sltu)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, on port reset.
- Reset values: state=IDLE; busy, done, div_by_zero = 0; result, result_hi = 0; alu_a, alu_b = 0; alu_op = 5'b00010 (add). Reset mid-operation aborts to IDLE in the next cycle and outputs take these values.
- ALU opcodes used: add 5'b00010, sltu 5'b00111 (Result=A-B, Set=A<B). No other opcode is issued.
- FSM, fixed latency for every operation:
  - IDLE: when start=1, latch md_op, a, b. Set sgn = md_op is MULT or DIV. Clear div_by_zero. Go to NEG_A.
  - NEG_A: alu_a=0, alu_b=opA, alu_op=sltu. If sgn and opA[31], opA<=alu_result. Go to NEG_B.
  - NEG_B: same treatment for opB. Go to ITER with cnt=0.
  - ITER, multiply (32 cycles). P_hi starts at 0, P_lo=opB. alu_a=P_hi, alu_b=opA, op=add. If P_lo[0]: {P_hi,P_lo} <= {alu_carryout, alu_result, P_lo}>>1. Else: {P_hi,P_lo} <= {1'b0, P_hi, P_lo}>>1.
  - ITER, divide (32 cycles). R starts at 0, Q=opA. alu_a={R[30:0],Q[31]}, alu_b=opB, op=sltu. take = R[31] | ~alu_set. If take: R<=alu_result. Else: R<=alu_a. In both cases Q<={Q[30:0],take}.
  - ITER exit: cnt increments each cycle; leave ITER after cnt=31.
  - FIX_LO: alu_a=0, alu_b=low word (P_lo or Q), op=sltu. Negate the low word if sgn and (a[31]^b[31]).
  - FIX_HI: negate P_hi if sgn and (a[31]^b[31]). Negate R if sgn and divide and a[31].
  - DONE: result and result_hi registered; done=1; busy=1. Next state IDLE.
- Latency: start accepted in cycle 0 → done in cycle 37. A new start is accepted in the cycle after DONE.
- start while busy is ignored. Inputs a, b, md_op are don't-care after acceptance.
- Divide by zero (DIV/DIVU with b==0): full latency still elapses. Outputs are forced to div_by_zero=1, result=32'hFFFF_FFFF, result_hi=a (original value).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: result=0x80000000, result_hi=0. No flag.
- Between operations, result and result_hi hold their last values.
- In IDLE and DONE, ALU outputs are at the reset values. Other users of the shared ALU may mux over them only when busy=0.

Decomposition:
- Package dlx_alu_pkg:
  - ALU opcode localparams (ALU_ADD, ALU_SLTU, etc.)
  - md_op encodings
  - md_state enum (IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE)
  - MD_LATENCY=37
- No sub-module. The ALU is external and shared; the sequencer contains only the FSM, counter and shift registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → result_hi=0xFFFFFFFE, result=0x00000001; done exactly 37 cycles after start; busy high cycles 1–37.
- MULT a=0xFFFFFFFD(-3) b=7 → result_hi=0xFFFFFFFF, result=0xFFFFFFEB(-21); MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9(-7) b=2 → result=0xFFFFFFFD(-3), result_hi=0xFFFFFFFF(-1); DIV 0x80000000/0xFFFFFFFF → result=0x80000000, hi=0.
- DIVU a=0xFFFFFFFF b=0x80000001 → result=1, result_hi=0x7FFFFFFE (exercises the R[31] path); DIVU 100/7 → 14 rem 2.
- DIVU a=0x1234 b=0 → div_by_zero=1, result=0xFFFFFFFF, result_hi=0x1234 at cycle 37; next start clears div_by_zero.
- Start MULTU, then pulse start with new operands at cycle 5 (ignored) and assert reset at cycle 10 → IDLE, all outputs at reset values next cycle. A start two cycles later completes correctly at +37.
